// File: rtl/emisor.sv
// rtl/emisor.sv - parallel-to-serial frame transmitter, MSB first, with enable strobe and gap
module emisor #(
   parameter int SIZESREG   = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [SIZESREG-1:0] data_in,
   input  logic                data_valid,
   output logic                data_ready,
   output logic                enable_out,
   output logic                signal_out,
   output logic                frame_done
);

   localparam int BW = $clog2(SIZESREG);
   localparam int GW = $clog2(GAP_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t              state, state_nx;
   logic [SIZESREG-1:0] shreg, shreg_nx;
   logic [BW-1:0]       bit_cnt, bit_cnt_nx;
   logic [GW-1:0]       gap_cnt, gap_cnt_nx;
   logic                enable_nx, signal_nx, done_nx;

   assign data_ready = (state == IDLE) && !RST;

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      gap_cnt_nx = gap_cnt;
      enable_nx  = 1'b0;
      signal_nx  = 1'b0;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (data_valid && data_ready) begin
               shreg_nx   = data_in;
               bit_cnt_nx = BW'(SIZESREG - 1);
               state_nx   = SHIFT;
               enable_nx  = 1'b1;
               signal_nx  = data_in[SIZESREG-1];
            end
         end
         SHIFT: begin
            if (bit_cnt == '0) begin
               done_nx    = 1'b1;
               gap_cnt_nx = GW'(GAP_CYCLES - 1);
               state_nx   = GAP;
            end else begin
               // shreg MSB is the bit currently on the line; the next one sits just below it
               bit_cnt_nx = bit_cnt - BW'(1);
               shreg_nx   = {shreg[SIZESREG-2:0], 1'b0};
               enable_nx  = 1'b1;
               signal_nx  = shreg[SIZESREG-2];
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt - GW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         enable_out <= 1'b0;
         signal_out <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         shreg      <= shreg_nx;
         bit_cnt    <= bit_cnt_nx;
         gap_cnt    <= gap_cnt_nx;
         enable_out <= enable_nx;
         signal_out <= signal_nx;
         frame_done <= done_nx;
      end
   end

endmodule

// File: tb/tb_emisor.sv
// tb/tb_emisor.sv - self-checking bench for emisor: timeline model, receiver scoreboard, directed tests
module tb_emisor;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] d16;
   logic        v16, rdy16, en16, sig16, fd16;
   logic [7:0]  d8;
   logic        v8, rdy8, en8, sig8, fd8;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_on = 1'b0;
   int cyc = 0;

   always #5 CLK = ~CLK;

   emisor #(.SIZESREG(16), .GAP_CYCLES(2)) dut16 (
      .CLK(CLK), .RST(RST), .data_in(d16), .data_valid(v16),
      .data_ready(rdy16), .enable_out(en16), .signal_out(sig16), .frame_done(fd16));

   emisor #(.SIZESREG(8), .GAP_CYCLES(1)) dut8 (
      .CLK(CLK), .RST(RST), .data_in(d8), .data_valid(v8),
      .data_ready(rdy8), .enable_out(en8), .signal_out(sig8), .frame_done(fd8));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: position within a frame; -1 idle, 1..S bit cycles, S+1..S+G gap cycles
   int          pos16 = -1, pos8 = -1;
   logic [15:0] word16 = '0;
   logic [7:0]  word8 = '0;
   int          hs16 = 0, hs8 = 0;

   always @(posedge CLK) begin
      cyc++;
      if (RST) begin
         pos16 = -1;
         pos8  = -1;
      end else begin
         if (pos16 < 0) begin
            if (v16) begin word16 = d16; pos16 = 1; hs16++; end
         end else if (pos16 == 16 + 2) pos16 = -1;
         else pos16++;
         if (pos8 < 0) begin
            if (v8) begin word8 = d8; pos8 = 1; hs8++; end
         end else if (pos8 == 8 + 1) pos8 = -1;
         else pos8++;
      end
   end

   // Receiver model and scoreboard
   logic [15:0] rx16 = '0, last_rx16 = '0;
   logic [7:0]  rx8 = '0, last_rx8 = '0;
   logic [15:0] q16[$];
   logic [7:0]  q8[$];
   int len16 = 0, last_len16 = 0, len8 = 0, last_len8 = 0;
   int n_fd16 = 0, n_fd8 = 0;
   logic pen16 = 1'b0;
   int rise16[$];

   always @(negedge CLK) begin
      logic e_en, e_sig;
      if (cmp_on) begin
         e_en  = (pos16 >= 1) && (pos16 <= 16);
         e_sig = e_en ? word16[16-pos16] : 1'b0;
         check("en16", {31'd0, en16}, {31'd0, e_en});
         check("sig16", {31'd0, sig16}, {31'd0, e_sig});
         check("fd16", {31'd0, fd16}, {31'd0, pos16 == 17});
         check("rdy16", {31'd0, rdy16}, {31'd0, (pos16 < 0) && !RST});
         e_en  = (pos8 >= 1) && (pos8 <= 8);
         e_sig = e_en ? word8[8-pos8] : 1'b0;
         check("en8", {31'd0, en8}, {31'd0, e_en});
         check("sig8", {31'd0, sig8}, {31'd0, e_sig});
         check("fd8", {31'd0, fd8}, {31'd0, pos8 == 9});
         check("rdy8", {31'd0, rdy8}, {31'd0, (pos8 < 0) && !RST});

         if (en16) begin
            rx16 = {rx16[14:0], sig16};
            if (!pen16) begin len16 = 1; rise16.push_back(cyc); end
            else len16++;
         end
         pen16 = en16;
         if (fd16) begin
            n_fd16++;
            last_rx16  = rx16;
            last_len16 = len16;
            if (q16.size() == 0) check("rx16_unexpected_frame", {16'd0, rx16}, 32'hFFFF_FFFF);
            else check("rx16_word", {16'd0, rx16}, {16'd0, q16.pop_front()});
         end
         if (en8) begin
            rx8 = {rx8[6:0], sig8};
            len8++;
         end else if (!fd8) len8 = 0;
         if (fd8) begin
            n_fd8++;
            last_rx8  = rx8;
            last_len8 = len8;
            if (q8.size() == 0) check("rx8_unexpected_frame", {24'd0, rx8}, 32'hFFFF_FFFF);
            else check("rx8_word", {24'd0, rx8}, {24'd0, q8.pop_front()});
         end
      end
   end

   task automatic wait_hs16(input int h);
      for (int i = 0; i < 100 && hs16 == h; i++) @(posedge CLK);
      #1;
      if (hs16 == h) check("timeout_hs16", 0, 1);
   endtask

   task automatic send16(input logic [15:0] w);
      int h = hs16;
      d16 = w; v16 = 1'b1;
      q16.push_back(w);
      wait_hs16(h);
      v16 = 1'b0;
   endtask

   task automatic wait_fd16();
      int f = n_fd16;
      for (int i = 0; i < 100 && n_fd16 == f; i++) @(posedge CLK);
      #1;
      if (n_fd16 == f) check("timeout_fd16", 0, 1);
   endtask

   initial begin
      int h, f;
      RST = 1'b1; v16 = 1'b0; d16 = '0; v8 = 1'b0; d8 = '0;
      repeat (3) @(posedge CLK);
      #1 cmp_on = 1'b1;
      @(negedge CLK);
      check("rdy_in_reset", {31'd0, rdy16}, 0);
      check("en_in_reset", {31'd0, en16}, 0);
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      check("rdy_after_reset", {31'd0, rdy16}, 1);

      // 1: single frame
      send16(16'hA5C3);
      @(negedge CLK);
      check("rdy_after_hs", {31'd0, rdy16}, 0);
      wait_fd16();
      check("len_A5C3", last_len16, 16);
      check("rx_A5C3", {16'd0, last_rx16}, 32'hA5C3);

      // 2: back-to-back with valid held
      rise16.delete();
      d16 = 16'h0001; v16 = 1'b1; q16.push_back(16'h0001);
      h = hs16; wait_hs16(h);
      d16 = 16'hFFFF; q16.push_back(16'hFFFF);
      h = hs16; wait_hs16(h);
      v16 = 1'b0;
      wait_fd16();
      check("rx_FFFF", {16'd0, last_rx16}, 32'hFFFF);
      check("rise_count", rise16.size(), 2);
      if (rise16.size() == 2) check("rise_period", rise16[1] - rise16[0], 19);

      // 3: valid during SHIFT is ignored
      send16(16'h00FF);
      h = hs16;
      repeat (4) @(posedge CLK);
      #1 d16 = 16'h1234; v16 = 1'b1;
      @(posedge CLK); #1 v16 = 1'b0;
      @(negedge CLK);
      check("rdy_busy", {31'd0, rdy16}, 0);
      wait_fd16();
      check("rx_00FF", {16'd0, last_rx16}, 32'h00FF);
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      check("no_1234_frame", {31'd0, en16}, 0);
      check("hs_unchanged", hs16 - h, 0);

      // 4: reset in SHIFT cycle 7
      f = n_fd16;
      d16 = 16'hFFFF; v16 = 1'b1;
      h = hs16; wait_hs16(h);
      v16 = 1'b0;
      repeat (7) @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      check("rdy_rst_mid", {31'd0, rdy16}, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("rst_en", {31'd0, en16}, 0);
      check("rst_sig", {31'd0, sig16}, 0);
      check("rst_fd", {31'd0, fd16}, 0);
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      check("rdy_after_abort", {31'd0, rdy16}, 1);
      check("no_fd_on_abort", n_fd16 - f, 0);

      // 6: data_in churn during SHIFT
      f = n_fd16;
      send16(16'hC0DE);
      for (int i = 0; i < 20; i++) begin
         d16 = 16'($urandom);
         @(posedge CLK); #1;
      end
      check("fd_C0DE", n_fd16 - f, 1);
      check("rx_C0DE", {16'd0, last_rx16}, 32'hC0DE);

      // 5: 8-bit instance, GAP=1
      f = n_fd8;
      d8 = 8'h81; v8 = 1'b1; q8.push_back(8'h81);
      h = hs8;
      for (int i = 0; i < 50 && hs8 == h; i++) @(posedge CLK);
      #1 v8 = 1'b0;
      if (hs8 == h) check("timeout_hs8", 0, 1);
      for (int i = 0; i < 50 && n_fd8 == f; i++) @(posedge CLK);
      #1;
      if (n_fd8 == f) check("timeout_fd8", 0, 1);
      check("len_81", last_len8, 8);
      check("rx_81", {24'd0, last_rx8}, 32'h81);
      @(negedge CLK);
      check("rdy8_after_gap", {31'd0, rdy8}, 1);

      repeat (3) @(posedge CLK);
      #1;
      check("q16_drained", q16.size(), 0);
      check("q8_drained", q8.size(), 0);
      cmp_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
